ptp_rom_streamer: RTL
=====================

// Module: ptp_rom_streamer
// PURPOSE
// - Reads a stored PTP frame template from the 1024x32 template ROM and streams it out as
//   Avalon-ST (32-bit, big-endian) toward the MAC TX path.
// - Drives the ROM address and consumes q. One frame per start pulse; handles MAC backpressure.
// - Optionally patches a live timestamp into the frame in flight.
// PARAMETERS
// - ROM_LAT  2  clocks from address to q valid; legal values 1 or 2.
// - FIFO_DW  2  log2 depth of the output FIFO. Depth 4 must be greater than ROM_LAT+1.
// - TS_OFS   8  word index within the frame of the first timestamp word (used only with the macro).
// PORTS
// - clock          in   1   system clock
// - reset          in   1   synchronous, active-high
// - start          in   1   one-cycle pulse; launches a frame when idle
// - base_addr      in   10  first ROM word of the template; sampled on start
// - len_words      in   11  frame length in words, 0..1024; sampled on start
// - last_empty     in   2   empty bytes in the last word; sampled on start
// - rom_address    out  10  to ROM address
// - rom_q          in   32  from ROM q
// - tx_data        out  32  Avalon-ST data
// - tx_valid       out  1   Avalon-ST valid
// - tx_ready       in   1   Avalon-ST ready (readyLatency 0)
// - tx_sop/tx_eop  out  1   start/end of packet
// - tx_empty       out  2   equals last_empty on the eop beat, 0 on all other beats
// - busy           out  1   high from the accepted start until done
// - done           out  1   one-cycle pulse after the eop beat is accepted
// BEHAVIOUR
// - Reset: rom_address=0, tx_valid=0, tx_sop=0, tx_eop=0, tx_empty=0, tx_data=0, busy=0,
//   done=0, FIFO empty, in-flight pipe cleared, FSM=IDLE.
// - FSM states IDLE -> RUN -> DRAIN -> IDLE.
//   - IDLE + start: latch inputs, set issued=0, go to RUN. busy goes high the next cycle.
//     If len_words=0, skip RUN and go straight to DRAIN; done pulses 1 cycle later and no beats are sent.
//   - RUN: issue one read per cycle when credit allows. Credit condition:
//     fifo_count + inflight + 1 <= depth.
//     rom_address = base_addr + issued, modulo 1024 (wraps at 1023 -> 0).
//     Move to DRAIN after issuing len_words reads.
//   - DRAIN: wait until inflight=0 and the FIFO is empty and the eop beat has been accepted.
//     Then pulse done, clear busy, return to IDLE.
// - A shift register of depth ROM_LAT tags each read with {valid, sop, eop, idx}.
//   rom_q is written to the FIFO together with these tags.
// - Credit accounting guarantees the FIFO never overflows. No data is dropped under any
//   tx_ready pattern.
// - tx_* comes from the FIFO head. tx_valid = !fifo_empty. A pop happens on tx_valid & tx_ready.
//   While tx_valid=1 and tx_ready=0, tx_data/sop/eop/empty must stay stable.
// - Throughput: 1 word/clock with tx_ready held high. First tx_valid appears ROM_LAT+1 clocks
//   after start.
// - start while busy is ignored; no state change.
// - reset mid-frame aborts the frame at once. No eop is emitted and no done pulse is produced.
// - len_words=1: a single beat with sop=eop=1.
// CONFIGURATION
// - Macro PTP_TS_INSERT_EN.
//   - Defined: adds ports ts_sec (in 32) and ts_ns (in 32), both sampled on start.
//   - Frame words at idx TS_OFS and TS_OFS+1 are replaced by ts_sec and ts_ns before the FIFO.
//     Replacement applies only if the index is < len_words.
//   - Undefined: no ts ports; ROM data passes through unchanged.
// STRUCTURE
// - Package ptp_stream_pkg holds:
//   - ROM_AW=10, ROM_DW=32
//   - typedef st_beat_t {data[31:0], sop, eop, empty[1:0]}
//   - enum state_t {IDLE, RUN, DRAIN}
// - Sub-module ptp_st_fifo: synchronous FIFO of st_beat_t, parameterised by FIFO_DW,
//   with count output. Everything else stays in the top level.
// TESTING
// - Use a behavioural ROM model with mem[i]=32'hA5000000|i and ROM_LAT set to 1 and to 2.
// - base=0, len=4, empty=2, tx_ready=1:
//   beats A5000000..A5000003 on consecutive cycles; sop on beat 0; eop+empty=2 on beat 3;
//   done 1 clk after the eop handshake.
// - base=1022, len=4: addresses 1022, 1023, 0, 1 -> data A50003FE, A50003FF, A5000000, A5000001.
// - len=16 with tx_ready toggled randomly (50%):
//   all 16 words in order; data held while stalled; FIFO count never exceeds 4.
// - len=0: done 1 clk after DRAIN entry; tx_valid stays 0.
//   len=1: one beat with sop=eop=1.
// - start pulsed again mid-frame: ignored. reset at beat 5 of a 10-word frame:
//   all outputs at reset values next clk, no done; a new start then runs correctly.
// - PTP_TS_INSERT_EN defined, TS_OFS=8, len=12, ts_sec=0x11223344, ts_ns=0x55667788:
//   words 8 and 9 carry the timestamp; all other words come from the ROM.

Source files
------------

// File: rtl/ptp_stream_pkg.sv
// Shared types and widths for the PTP template ROM streamer.
package ptp_stream_pkg;

  localparam int ROM_AW = 10;
  localparam int ROM_DW = 32;
  localparam int LEN_W  = ROM_AW + 1;

  typedef struct packed {
    logic [ROM_DW-1:0] data;
    logic              sop;
    logic              eop;
    logic [1:0]        empty;
  } st_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/ptp_st_fifo.sv
// Synchronous FIFO of Avalon-ST beats with an occupancy count; depth is 2**FIFO_DW.
module ptp_st_fifo
  import ptp_stream_pkg::*;
#(
  parameter int FIFO_DW = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  st_beat_t         wr_data,
  input  logic             rd_en,
  output st_beat_t         rd_data,
  output logic [FIFO_DW:0] count,
  output logic             empty
);

  localparam int DEPTH = 1 << FIFO_DW;

  st_beat_t           mem [DEPTH];
  logic [FIFO_DW-1:0] wr_ptr;
  logic [FIFO_DW-1:0] rd_ptr;
  logic               full;
  logic               do_wr;
  logic               do_rd;

  assign full    = count[FIFO_DW];
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ptp_rom_streamer.sv
// Streams a PTP frame template from the 1024x32 ROM as big-endian Avalon-ST with backpressure.
// Optional live timestamp patching is enabled by defining PTP_TS_INSERT_EN.
module ptp_rom_streamer
  import ptp_stream_pkg::*;
#(
  parameter int ROM_LAT = 2,
  parameter int FIFO_DW = 2,
  parameter int TS_OFS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [1:0]        last_empty,
`ifdef PTP_TS_INSERT_EN
  input  logic [31:0]       ts_sec,
  input  logic [31:0]       ts_ns,
`endif
  output logic [ROM_AW-1:0] rom_address,
  input  logic [ROM_DW-1:0] rom_q,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [1:0]        tx_empty,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << FIFO_DW;
  localparam int CW    = FIFO_DW + 2;

  // Word index is carried only when it is needed to place the timestamp.
  typedef struct packed {
    logic             valid;
    logic             sop;
    logic             eop;
`ifdef PTP_TS_INSERT_EN
    logic [LEN_W-1:0] idx;
`endif
  } rd_tag_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [1:0]       empty_q;
`ifdef PTP_TS_INSERT_EN
  logic [31:0]      ts_sec_q;
  logic [31:0]      ts_ns_q;
`endif

  rd_tag_t          pipe [ROM_LAT];
  rd_tag_t          tail;
  logic [FIFO_DW:0] inflight;
  logic [FIFO_DW:0] fifo_count;
  logic             fifo_empty;
  logic [CW-1:0]    occupancy;
  logic             credit;
  st_beat_t         wr_beat;
  st_beat_t         head;

  assign tail = pipe[ROM_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) inflight = inflight + {{FIFO_DW{1'b0}}, pipe[i].valid};
  end

  // A read is only issued if its word is guaranteed a FIFO slot when it returns.
  assign occupancy = CW'(fifo_count) + CW'(inflight) + CW'(1);
  assign credit    = (occupancy <= CW'(DEPTH));

  // NOTE: every field gets a default first so no path through this block can infer a latch.
  always_comb begin
    wr_beat.data = rom_q;
`ifdef PTP_TS_INSERT_EN
    if (tail.idx == LEN_W'(TS_OFS))          wr_beat.data = ts_sec_q;
    else if (tail.idx == LEN_W'(TS_OFS + 1)) wr_beat.data = ts_ns_q;
`endif
    wr_beat.sop   = tail.sop;
    wr_beat.eop   = tail.eop;
    wr_beat.empty = tail.eop ? empty_q : 2'b00;
  end

  ptp_st_fifo #(.FIFO_DW(FIFO_DW)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (tail.valid),
    .wr_data (wr_beat),
    .rd_en   (tx_valid && tx_ready),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign tx_valid = !fifo_empty;
  assign tx_data  = tx_valid ? head.data  : '0;
  assign tx_sop   = tx_valid && head.sop;
  assign tx_eop   = tx_valid && head.eop;
  assign tx_empty = tx_valid ? head.empty : 2'b00;

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rom_address <= '0;
      len_q       <= '0;
      issued      <= '0;
      empty_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
`ifdef PTP_TS_INSERT_EN
      ts_sec_q    <= '0;
      ts_ns_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
      pipe[0] <= '0;

      unique case (state)
        IDLE: begin
          if (start) begin
            rom_address <= base_addr;
            len_q       <= len_words;
            empty_q     <= last_empty;
            issued      <= '0;
            busy        <= 1'b1;
`ifdef PTP_TS_INSERT_EN
            ts_sec_q    <= ts_sec;
            ts_ns_q     <= ts_ns;
`endif
            state       <= (len_words == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (credit) begin
            pipe[0].valid <= 1'b1;
            pipe[0].sop   <= (issued == '0);
            pipe[0].eop   <= (issued == len_q - 1'b1);
`ifdef PTP_TS_INSERT_EN
            pipe[0].idx   <= issued;
`endif
            issued        <= issued + 1'b1;
            rom_address   <= rom_address + 1'b1;
            if (issued + 1'b1 == len_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0 && fifo_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
